wb_stage: RTL and testbench

Writeback stage of the 5-stage RV32I pipeline. Holds the MEM/WB pipeline register, selects the architectural result, and drives the register-file write port and the hazard unit's W-stage inputs. It also owns the 64-bit `cycle` and `instret` performance counters, with a CSR-side write port for preload.

---
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select, register-file write port,
// and the 64-bit cycle/instret performance counters with a 32-bit preload port.
package wb_stage_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef struct packed {
        logic              RegWrite;
        logic [1:0]        ResultSrc;
        logic [DATA_W-1:0] ALUResult;
        logic [REG_W-1:0]  Rd;
        logic [DATA_W-1:0] PCPlus4;
        logic [DATA_W-1:0] ImmExt;
        logic [DATA_W-1:0] load_data;
    } memwb_t;
endpackage

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  memwb_t          inputs,
    input  logic            ValidM,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic            CsrWrite,
    input  logic [1:0]      CsrAddr,
    input  logic [31:0]     CsrWData,
    output logic [XLEN-1:0] ResultW,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic            ValidW,
    output logic [63:0]     cycle,
    output logic [63:0]     instret
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_PC4  = 2'd2;
    localparam logic [1:0] SRC_IMM  = 2'd3;

    localparam logic [1:0] CSR_CYC_LO = 2'd0;
    localparam logic [1:0] CSR_CYC_HI = 2'd1;
    localparam logic [1:0] CSR_INS_LO = 2'd2;
    localparam logic [1:0] CSR_INS_HI = 2'd3;

    memwb_t            r_w;
    logic              r_valid;
    logic [63:0]       r_cycle;
    logic [63:0]       r_instret;
    logic [DATA_W-1:0] w_result;
    logic              w_retire;
    logic              w_cyc_wr;
    logic              w_ins_wr;

    // W register: flush inserts a bubble and outranks stall
    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            r_w     <= '0;
            r_valid <= 1'b0;
        end else if (!StallW) begin
            r_w     <= inputs;
            r_valid <= ValidM;
        end
    end

    always_comb begin
        w_result = r_w.ALUResult;
        unique case (r_w.ResultSrc)
            SRC_ALU:  w_result = r_w.ALUResult;
            SRC_LOAD: w_result = r_w.load_data;
            SRC_PC4:  w_result = r_w.PCPlus4;
            SRC_IMM:  w_result = r_w.ImmExt;
            default:  w_result = r_w.ALUResult;
        endcase
    end

    // An instruction retires only on the edge it actually leaves W
    assign w_retire = r_valid & ~StallW & ~FlushW;
    assign w_cyc_wr = CsrWrite & ~CsrAddr[1];
    assign w_ins_wr = CsrWrite &  CsrAddr[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= 64'd0;
        end else if (w_cyc_wr && (CsrAddr == CSR_CYC_LO)) begin
            r_cycle[31:0] <= CsrWData;
        end else if (w_cyc_wr && (CsrAddr == CSR_CYC_HI)) begin
            r_cycle[63:32] <= CsrWData;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= 64'd0;
        end else if (w_ins_wr && (CsrAddr == CSR_INS_LO)) begin
            r_instret[31:0] <= CsrWData;
        end else if (w_ins_wr && (CsrAddr == CSR_INS_HI)) begin
            r_instret[63:32] <= CsrWData;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign ResultW   = XLEN'(w_result);
    assign RdW       = r_w.Rd;
    assign RegWriteW = r_w.RegWrite & r_valid & (r_w.Rd != 5'd0);
    assign ValidW    = r_valid;
    assign cycle     = r_cycle;
    assign instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a reference model predicts post-edge outputs into a queue.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        reset;
    memwb_t      inputs;
    logic        ValidM, StallW, FlushW, CsrWrite;
    logic [1:0]  CsrAddr;
    logic [31:0] CsrWData;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, ValidW;
    logic [63:0] cycle, instret;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        vld;
        logic [63:0] cyc;
        logic [63:0] ins;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;

    logic        m_vld, m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [63:0] m_cyc, m_ins;

    wb_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .inputs    (inputs),
        .ValidM    (ValidM),
        .StallW    (StallW),
        .FlushW    (FlushW),
        .CsrWrite  (CsrWrite),
        .CsrAddr   (CsrAddr),
        .CsrWData  (CsrWData),
        .ResultW   (ResultW),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ValidW    (ValidW),
        .cycle     (cycle),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_result(input memwb_t m);
        case (m.ResultSrc)
            2'd0:    return m.ALUResult;
            2'd1:    return m.load_data;
            2'd2:    return m.PCPlus4;
            default: return m.ImmExt;
        endcase
    endfunction

    task automatic rand_inputs();
        inputs.RegWrite  = 1'($urandom);
        inputs.ResultSrc = 2'($urandom);
        inputs.ALUResult = $urandom;
        inputs.Rd        = 5'($urandom);
        inputs.PCPlus4   = $urandom;
        inputs.ImmExt    = $urandom;
        inputs.load_data = $urandom;
    endtask

    task automatic idle();
        reset = 1'b0; ValidM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        CsrWrite = 1'b0; CsrAddr = 2'd0; CsrWData = 32'd0;
    endtask

    // Predict the state after the coming edge, push it, clock, then pop and compare
    task automatic step();
        exp_t e;
        logic ret;
        if (reset) begin
            m_vld = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_res = 32'd0;
            m_cyc = 64'd0; m_ins = 64'd0;
        end else begin
            ret = m_vld & ~StallW & ~FlushW;
            if (CsrWrite && CsrAddr == 2'd0)      m_cyc[31:0]  = CsrWData;
            else if (CsrWrite && CsrAddr == 2'd1) m_cyc[63:32] = CsrWData;
            else                                  m_cyc        = m_cyc + 64'd1;
            if (CsrWrite && CsrAddr == 2'd2)      m_ins[31:0]  = CsrWData;
            else if (CsrWrite && CsrAddr == 2'd3) m_ins[63:32] = CsrWData;
            else if (ret)                         m_ins        = m_ins + 64'd1;
            if (FlushW) begin
                m_vld = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_res = 32'd0;
            end else if (!StallW) begin
                m_vld = ValidM; m_we = inputs.RegWrite; m_rd = inputs.Rd;
                m_res = sel_result(inputs);
            end
        end
        e.res = m_res; e.rd = m_rd; e.we = m_we & m_vld & (m_rd != 5'd0);
        e.vld = m_vld; e.cyc = m_cyc; e.ins = m_ins;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ResultW",   64'(ResultW),   64'(e.res));
            chk("RdW",       64'(RdW),       64'(e.rd));
            chk("RegWriteW", 64'(RegWriteW), 64'(e.we));
            chk("ValidW",    64'(ValidW),    64'(e.vld));
            chk("cycle",     cycle,          e.cyc);
            chk("instret",   instret,        e.ins);
        end
    endtask

    initial begin
        logic [31:0] lit [4];
        logic [63:0] snap_i, snap_c;
        n_vec = 0; n_err = 0;
        lit[0] = 32'h11; lit[1] = 32'h22; lit[2] = 32'h33; lit[3] = 32'h44;
        m_vld = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_res = 32'd0; m_cyc = 64'd0; m_ins = 64'd0;
        idle();
        inputs = '0;

        // Reset with random inputs for three cycles
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1; ValidM = 1'b1; StallW = 1'($urandom); FlushW = 1'($urandom);
            rand_inputs();
            step();
            chk("rst_cycle", cycle, 64'd0);
            chk("rst_valid", 64'(ValidW), 64'd0);
        end
        idle();
        step();
        chk("post_rst_cycle", cycle, 64'd1);
        chk("post_rst_instret", instret, 64'd0);

        // Result mux over all four sources
        for (int s = 0; s < 4; s++) begin
            idle();
            inputs.RegWrite = 1'b1; inputs.ResultSrc = 2'(s); inputs.Rd = 5'd5;
            inputs.ALUResult = 32'h11; inputs.load_data = 32'h22;
            inputs.PCPlus4 = 32'h33; inputs.ImmExt = 32'h44;
            ValidM = 1'b1;
            step();
            chk("mux_result", 64'(ResultW), 64'(lit[s]));
            chk("mux_we", 64'(RegWriteW), 64'd1);
            chk("mux_rd", 64'(RdW), 64'd5);
        end

        // Write to x0 is suppressed but still retires
        idle();
        inputs.Rd = 5'd0; inputs.RegWrite = 1'b1; ValidM = 1'b1;
        step();
        chk("x0_we", 64'(RegWriteW), 64'd0);
        snap_i = instret;
        idle();
        step();
        chk("x0_retire", instret, snap_i + 64'd1);

        // Stall for four cycles, count once on release
        idle();
        inputs.Rd = 5'd7; ValidM = 1'b1;
        step();
        snap_i = instret;
        for (int i = 0; i < 4; i++) begin
            idle(); StallW = 1'b1; ValidM = 1'b1; rand_inputs();
            step();
            chk("stall_hold", instret, snap_i);
            chk("stall_rd", 64'(RdW), 64'd7);
        end
        idle();
        step();
        chk("stall_release", instret, snap_i + 64'd1);

        // Stall and flush together: flush wins, nothing counted
        idle(); inputs.Rd = 5'd9; ValidM = 1'b1;
        step();
        snap_i = instret;
        idle(); StallW = 1'b1; FlushW = 1'b1;
        step();
        chk("flush_valid", 64'(ValidW), 64'd0);
        chk("flush_instret", instret, snap_i);

        // cycle preload and wrap
        idle(); CsrWrite = 1'b1; CsrAddr = 2'd0; CsrWData = 32'hFFFF_FFFF;
        step();
        CsrAddr = 2'd1;
        step();
        chk("cyc_ones", cycle, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        step();
        chk("cyc_wrap", cycle, 64'd0);

        // instret preload and wrap on one retire
        idle(); CsrWrite = 1'b1; CsrAddr = 2'd2; CsrWData = 32'hFFFF_FFFF;
        step();
        CsrAddr = 2'd3; ValidM = 1'b1;
        step();
        chk("ins_ones", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        step();
        chk("ins_wrap", instret, 64'd0);

        // CSR write collides with a retire: write wins, cycle still counts
        idle(); ValidM = 1'b1;
        step();
        snap_c = cycle;
        idle(); CsrWrite = 1'b1; CsrAddr = 2'd2; CsrWData = 32'h100;
        step();
        chk("coll_instret", instret, 64'h100);
        chk("coll_cycle", cycle, snap_c + 64'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            idle(); rand_inputs();
            ValidM = 1'($urandom);
            StallW = ($urandom_range(0, 3) == 0);
            FlushW = ($urandom_range(0, 7) == 0);
            CsrWrite = ($urandom_range(0, 9) == 0);
            CsrAddr = 2'($urandom);
            CsrWData = $urandom;
            step();
        end

        // Reset while stalled and flushing
        idle(); reset = 1'b1; StallW = 1'b1; FlushW = 1'b1; CsrWrite = 1'b1; ValidM = 1'b1;
        step();
        chk("midrst_cycle", cycle, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        idle();
        step();
        chk("midrst_first", cycle, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
